// File: rtl/icache_refill_bridge_pkg.sv
// Shared definitions for the instruction-cache refill bridge.
// - AXI encodings used on the read channels.
// - The controller state type. It is also exported on the top-level debug port.
package icache_refill_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/icache_refill_bridge_if.sv
// AXI-style read address and read data channels between the refill bridge and
// the memory-side port or arbiter.
//
// Handshake rule for both channels: a beat transfers on a rising clk edge where
// valid and ready are both high. Once valid is raised, the source holds it and
// its payload stable until that edge. Ready may depend on valid, but valid never
// depends on ready.
//
// Modports:
//   master : the bridge. Drives AR* and rready; receives arready and R*.
//   slave  : the memory side.
interface icache_refill_bridge_if #(
    parameter int WORD = 32
);
    logic [WORD-1:0] araddr;
    logic            arvalid;
    logic            arready;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [3:0]      arid;
    logic            rvalid;
    logic            rready;
    logic [WORD-1:0] rdata;
    logic [1:0]      rresp;
    logic            rlast;

    modport master (
        output araddr, arvalid, arlen, arsize, arburst, arid, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  araddr, arvalid, arlen, arsize, arburst, arid, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/icache_refill_bridge_refill_line_assembler.sv
// Cache-line holding register. The register is written one word at a time.
//   clk, rst : clock and asynchronous active-high clear
//   we       : write the word selected by sel
//   sel      : word index within the line (the beat counter)
//   wdata    : word to store
//   line     : assembled line. Word k occupies bits [k*WORD +: WORD].
module icache_refill_bridge_refill_line_assembler #(
    parameter int WORD       = 32,
    parameter int BEATS      = 4,
    parameter int LINE_WIDTH = 128,
    parameter int SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [SEL_W-1:0]      sel,
    input  logic [WORD-1:0]       wdata,
    output logic [LINE_WIDTH-1:0] line
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (we) begin
            for (int k = 0; k < BEATS; k++) begin
                if (sel == SEL_W'(k)) begin
                    line[k*WORD +: WORD] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/icache_refill_bridge.sv
// Instruction-cache refill bridge.
// The bridge turns one line-refill request into a single INCR read burst. It
// gathers the returned beats into a cache line and presents the line with a
// one-cycle mem_ready pulse.
//   clk, rst  : clock, asynchronous active-high reset
//   req_valid : refill request. It is accepted only in IDLE.
//   req_addr  : byte address of the miss. It is aligned down to the line.
//   cancel    : flush. The current refill is abandoned and its beats are drained.
//   mem_ready : one-cycle pulse. line_out is valid.
//   line_out  : assembled line. It holds until the next beat is written.
//   bus_err   : pulses with mem_ready. It is high if any beat had a bad response or a misplaced rlast.
//   busy      : high whenever the controller is not idle.
//   state_dbg : current controller state
//   axi       : read address and read data channels (master side)
module icache_refill_bridge
    import icache_refill_bridge_pkg::*;
#(
    parameter int          WORD       = 32,
    parameter int          LINE_WIDTH = 128,
    parameter int          BEATS      = 4,
    parameter logic [3:0]  ID         = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [WORD-1:0]       req_addr,
    input  logic                  cancel,
    output logic                  mem_ready,
    output logic [LINE_WIDTH-1:0] line_out,
    output logic                  bus_err,
    output logic                  busy,
    output state_t                state_dbg,
    icache_refill_bridge_if.master axi
);

    localparam int CW             = $clog2(BEATS);
    localparam int LINE_BYTE_LOG  = $clog2(LINE_WIDTH / 8);
    localparam int SIZE_LOG       = $clog2(WORD / 8);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            discard_q, discard_d;
    logic            err_q, err_d;
    logic [WORD-1:0] addr_q, addr_d;
    logic            line_we;
    logic            beat_last;
    logic [WORD-1:0] aligned_addr;

    assign aligned_addr = {req_addr[WORD-1:LINE_BYTE_LOG], {LINE_BYTE_LOG{1'b0}}};
    assign beat_last    = (cnt_q == LAST_BEAT);

    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'(BEATS - 1);
    assign axi.arsize  = 3'(SIZE_LOG);
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arid    = ID;
    assign state_dbg   = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        err_d       = err_q;
        addr_d      = addr_q;
        line_we     = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        mem_ready   = 1'b0;
        bus_err     = 1'b0;
        busy        = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (req_valid && !cancel) begin
                    addr_d  = aligned_addr;
                    state_d = S_ADDR;
                end
            end

            // The address handshake always completes, even after a cancel,
            // because the burst is then owed to us and must be drained.
            S_ADDR: begin
                axi.arvalid = 1'b1;
                if (cancel) discard_d = 1'b1;
                if (axi.arready) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end

            // The burst length comes from the beat count. rlast only
            // contributes to the error flag.
            S_DATA: begin
                axi.rready = 1'b1;
                if (cancel) discard_d = 1'b1;
                if (axi.rvalid) begin
                    line_we = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                    if (axi.rresp != AXI_RESP_OKAY || axi.rlast != beat_last) begin
                        err_d = 1'b1;
                    end
                    if (beat_last) begin
                        if (discard_q || cancel) begin
                            discard_d = 1'b0;
                            err_d     = 1'b0;
                            state_d   = S_IDLE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (discard_q || cancel) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (beat_last) begin
                        discard_d = 1'b0;
                        err_d     = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end

            S_DONE: begin
                mem_ready = 1'b1;
                bus_err   = err_q;
                err_d     = 1'b0;
                discard_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    icache_refill_bridge_refill_line_assembler #(
        .WORD       (WORD),
        .BEATS      (BEATS),
        .LINE_WIDTH (LINE_WIDTH),
        .SEL_W      (CW)
    ) u_line (
        .clk   (clk),
        .rst   (rst),
        .we    (line_we),
        .sel   (cnt_q),
        .wdata (axi.rdata),
        .line  (line_out)
    );

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Self-checking bench for icache_refill_bridge (WORD=32, LINE_WIDTH=128, BEATS=4).
module tb_icache_refill_bridge;
    import icache_refill_bridge_pkg::*;

    localparam int MAX_CYC = 300;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;       // beat k = data[k*32 +: 32]
        int           ar_delay;   // arvalid cycles before arready is given
        int           gap;        // idle rready cycles before each beat
        int           bad_beat;   // beat with rresp=SLVERR, -1 none
        int           bad_last;   // beat whose rlast is inverted, -1 none
        int           cancel_at;  // -1 none, 0 in ADDR, k after k beats
        logic [31:0]  exp_araddr;
        bit           exp_pulse;
        bit           exp_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         cancel = 1'b0;
    logic         mem_ready, bus_err, busy;
    logic [127:0] line_out;
    state_t       state_dbg;

    icache_refill_bridge_if #(.WORD(32)) axi ();

    icache_refill_bridge #(.WORD(32), .LINE_WIDTH(128), .BEATS(4), .ID(4'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .cancel    (cancel),
        .mem_ready (mem_ready),
        .line_out  (line_out),
        .bus_err   (bus_err),
        .busy      (busy),
        .state_dbg (state_dbg),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [128:0] exp_q[$];      // {bus_err, line} per expected mem_ready
    logic [127:0] model_line;
    logic [3:0]   model_known;
    vec_t         tbl[14];

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: the line is aligned to 16 bytes. A refill is delivered
    // only when it is not cancelled. The error flag is the OR of bad responses
    // and misplaced rlast.
    function automatic vec_t make_random();
        vec_t v;
        v.addr       = $urandom;
        v.data       = {$urandom, $urandom, $urandom, $urandom};
        v.ar_delay   = $urandom_range(0, 3);
        v.gap        = $urandom_range(0, 2);
        v.bad_beat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
        v.bad_last   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
        v.cancel_at  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
        v.exp_araddr = v.addr - (v.addr % 32'd16);
        v.exp_pulse  = (v.cancel_at < 0);
        v.exp_err    = v.exp_pulse && (v.bad_beat >= 0 || v.bad_last >= 0);
        return v;
    endfunction

    // Acts as both the requester and the memory slave for one refill.
    task automatic do_refill(input vec_t v, input string tag);
        int cyc, beats, ar_wait, gap_cnt, lb_cyc, mr_cyc, idle_cyc, mr_cnt, k;
        bit ar_seen, ar_done, ar_bad, cancel_done;
        logic [128:0] e;
        beats = 0; ar_wait = 0; gap_cnt = 0; lb_cyc = -1; mr_cyc = -1; idle_cyc = -1; mr_cnt = 0;
        ar_seen = 0; ar_done = 0; ar_bad = 0; cancel_done = 0;
        if (v.exp_pulse) exp_q.push_back({v.exp_err, v.data});

        req_valid = 1'b1;
        req_addr  = v.addr;
        cancel    = 1'b0;
        step();
        cyc = 1;
        req_valid = 1'b0;
        check({tag, "/ar_latency"}, {busy, axi.arvalid}, 2'b11);

        while (cyc < MAX_CYC && idle_cyc < 0) begin
            // observe the current cycle
            if (axi.arvalid) begin
                ar_seen = 1;
                if (axi.araddr !== v.exp_araddr) ar_bad = 1;
            end else if (ar_seen && !ar_done) begin
                ar_bad = 1;
            end
            if (mem_ready) begin
                mr_cnt++;
                mr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check({tag, "/unexpected_mem_ready"}, 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "/line"}, line_out, e[127:0]);
                    check({tag, "/bus_err"}, bus_err, e[128]);
                end
            end
            if (beats == 4 && !busy) begin
                idle_cyc = cyc;
            end else begin
                // drive the inputs for this cycle
                req_valid = busy ? 1'($urandom_range(0, 1)) : 1'b0;
                req_addr  = $urandom;
                cancel    = mem_ready ? 1'($urandom_range(0, 1)) : 1'b0;
                if (!cancel_done && v.cancel_at == 0 && axi.arvalid) begin
                    cancel = 1'b1; cancel_done = 1;
                end
                if (!cancel_done && v.cancel_at > 0 && axi.rready && beats == v.cancel_at) begin
                    cancel = 1'b1; cancel_done = 1;
                end
                axi.arready = axi.arvalid && (ar_wait >= v.ar_delay);
                if (axi.arvalid) begin
                    if (axi.arready) ar_done = 1;
                    ar_wait++;
                end
                axi.rvalid = 1'b0;
                axi.rdata  = $urandom;
                axi.rresp  = 2'($urandom_range(0, 3));
                axi.rlast  = 1'($urandom_range(0, 1));
                if (axi.rready && beats < 4) begin
                    if (gap_cnt >= v.gap) begin
                        axi.rvalid = 1'b1;
                        axi.rdata  = v.data[beats*32 +: 32];
                        axi.rresp  = (beats == v.bad_beat) ? 2'b10 : 2'b00;
                        axi.rlast  = (beats == 3) ^ (beats == v.bad_last);
                        beats++;
                        gap_cnt = 0;
                        lb_cyc  = cyc;
                    end else begin
                        gap_cnt++;
                    end
                end
                step();
                cyc++;
            end
        end
        req_valid = 1'b0; cancel = 1'b0; axi.arready = 1'b0; axi.rvalid = 1'b0;

        check({tag, "/timeout"}, (cyc < MAX_CYC), 1'b1);
        check({tag, "/ar_stable"}, {ar_done, ar_bad}, 2'b10);
        check({tag, "/beats_accepted"}, beats, 4);
        check({tag, "/mem_ready_count"}, mr_cnt, v.exp_pulse ? 1 : 0);
        if (v.exp_pulse) begin
            if (v.ar_delay == 0 && v.gap == 0) check({tag, "/mr_cycle"}, mr_cyc, 6);
            check({tag, "/idle_after_done"}, idle_cyc, mr_cyc + 1);
            check({tag, "/line_hold"}, line_out, v.data);
            model_line  = v.data;
            model_known = 4'hF;
        end else begin
            check({tag, "/busy_fall"}, idle_cyc, lb_cyc + 1);
            k = v.cancel_at;
            for (int w = k + 1; w < 4; w++) begin
                if (model_known[w]) check({tag, "/untouched_word"}, line_out[w*32 +: 32], model_line[w*32 +: 32]);
            end
            for (int w = 0; w <= k; w++) model_known[w] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
        model_line = '0; model_known = 4'hF;

        // addr, data{w3,w2,w1,w0}, ar_delay, gap, bad_beat, bad_last, cancel_at, exp_araddr, pulse, err
        tbl[0]  = '{32'h1C00_0024, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, -1, -1, -1, 32'h1C00_0020, 1'b1, 1'b0};
        tbl[1]  = '{32'h0000_1238, {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0}, 3, 2, -1, -1, -1, 32'h0000_1230, 1'b1, 1'b0};
        tbl[2]  = '{32'h8000_0004, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2, 0, -1, -1, 0, 32'h8000_0000, 1'b0, 1'b0};
        tbl[3]  = '{32'h4000_FFFC, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 0, 0, -1, -1, -1, 32'h4000_FFF0, 1'b1, 1'b0};
        tbl[4]  = '{32'h0000_0100, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0, 0, -1, -1, 1, 32'h0000_0100, 1'b0, 1'b0};
        tbl[5]  = '{32'h0000_0110, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0, 0, -1, -1, -1, 32'h0000_0110, 1'b1, 1'b0};
        tbl[6]  = '{32'h2000_0048, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 0, 0, 1, -1, -1, 32'h2000_0040, 1'b1, 1'b1};
        tbl[7]  = '{32'h2000_0050, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 0, 0, -1, -1, -1, 32'h2000_0050, 1'b1, 1'b0};
        tbl[8]  = '{32'h3000_0007, {32'h13, 32'h12, 32'h11, 32'h10}, 1, 0, -1, 3, -1, 32'h3000_0000, 1'b1, 1'b1};
        tbl[9]  = '{32'h3000_0019, {32'h23, 32'h22, 32'h21, 32'h20}, 0, 1, -1, 0, -1, 32'h3000_0010, 1'b1, 1'b1};
        tbl[10] = '{32'hFFFF_FFFF, {32'h33, 32'h32, 32'h31, 32'h30}, 1, 1, -1, -1, -1, 32'hFFFF_FFF0, 1'b1, 1'b0};
        tbl[11] = '{32'h0000_0200, {32'h43, 32'h42, 32'h41, 32'h40}, 0, 1, -1, -1, 3, 32'h0000_0200, 1'b0, 1'b0};
        tbl[12] = '{32'h0000_0300, {32'h53, 32'h52, 32'h51, 32'h50}, 0, 0, 2, -1, 1, 32'h0000_0300, 1'b0, 1'b0};
        tbl[13] = '{32'h0000_0310, {32'h63, 32'h62, 32'h61, 32'h60}, 0, 0, -1, -1, -1, 32'h0000_0310, 1'b1, 1'b0};

        // reset state and constant outputs
        step(); step();
        check("reset_ctrl", {mem_ready, bus_err, axi.arvalid, axi.rready, busy}, 5'b0);
        check("reset_araddr", axi.araddr, 32'h0);
        check("reset_line", line_out, 128'h0);
        check("reset_state", state_dbg, S_IDLE);
        check("arlen", axi.arlen, 8'd3);
        check("arsize", axi.arsize, 3'd2);
        check("arburst", axi.arburst, 2'b01);
        check("arid", axi.arid, 4'd0);
        rst = 1'b0;
        step();

        // a request together with cancel in IDLE is not accepted
        req_valid = 1'b1; cancel = 1'b1; req_addr = 32'h0000_5000;
        step();
        req_valid = 1'b0; cancel = 1'b0;
        check("idle_cancel_blocks_req", {busy, axi.arvalid}, 2'b00);
        step();

        for (int i = 0; i < 14; i++) do_refill(tbl[i], $sformatf("vec%0d", i));

        // reset arrives asynchronously during the third beat
        req_valid = 1'b1; req_addr = 32'h0000_7004;
        step();
        req_valid = 1'b0; axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rresp = 2'b00; axi.rlast = 1'b0;
        axi.rdata = 32'h7770; step();
        axi.rdata = 32'h7771; step();
        axi.rdata = 32'h7772;
        #3 rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {mem_ready, bus_err, axi.arvalid, axi.rready, busy}, 5'b0);
        check("rst_mid_araddr", axi.araddr, 32'h0);
        check("rst_mid_line", line_out, 128'h0);
        axi.rvalid = 1'b0;
        step();
        rst = 1'b0;
        model_line = '0; model_known = 4'hF;
        do_refill(tbl[0], "post_reset");
        step();

        for (int i = 0; i < 40; i++) do_refill(make_random(), $sformatf("rnd%0d", i));

        check("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
